// File: rtl/chan_wr_ctl_pkg.sv
// Shared command codes, FSM states and width helpers for the channel write controller.
package chan_wr_ctl_pkg;

  typedef enum logic [7:0] {
    CMD_CONF_WR  = 8'h2A,
    CMD_ADDR_WR  = 8'h2B,
    CMD_DATA_WR  = 8'h2C,
    CMD_CHAN_SEL = 8'h2D,
    CMD_BCAST_WR = 8'h2E
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONF,
    ST_CHSEL,
    ST_ADDR,
    ST_DATA,
    ST_BCAST,
    ST_DROP
  } state_t;

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chan_addr_seq.sv
// Lane/address/channel sequencer shared by the ADDR, DATA and BCAST write modes.
module chan_addr_seq
  import chan_wr_ctl_pkg::*;
#(
  parameter int unsigned CHAN_NUM   = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WORD_BYTES = 3,
  localparam int unsigned CW = clog2_min1(CHAN_NUM),
  localparam int unsigned BW = WORD_BYTES + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic                  addr_mode_i,
  input  logic                  bcast_i,
  input  logic [CW-1:0]         start_chan_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  input  logic [CW-1:0]         cnt_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [BW-1:0]         lane_en_o,
  output logic [CHAN_NUM-1:0]   chan_en_o,
  output logic                  last_o
);

  localparam int unsigned LW = clog2_min1(WORD_BYTES);

  logic [LW-1:0]         r_lane;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [CW-1:0]         r_chan;
  logic [CW-1:0]         r_cnt;

  logic w_word_end;
  logic w_addr_end;
  logic w_chan_end;

  // Address mode carries one byte per word; broadcast never leaves its channel set.
  assign w_word_end = addr_mode_i | (r_lane == LW'(WORD_BYTES - 1));
  assign w_addr_end = (r_addr == r_len);
  assign w_chan_end = bcast_i | (r_chan >= r_cnt);
  assign last_o     = w_word_end & w_addr_end & w_chan_end;
  assign addr_o     = r_addr;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_lane <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_chan <= '0;
      r_cnt  <= '0;
    end else if (clr_i) begin
      r_lane <= '0;
      r_addr <= '0;
      if (load_i) begin
        r_chan <= start_chan_i;
        r_len  <= len_i;
        r_cnt  <= cnt_i;
      end
    end else if (step_i) begin
      if (!w_word_end) begin
        r_lane <= r_lane + LW'(1);
      end else begin
        r_lane <= '0;
        if (!w_addr_end) begin
          r_addr <= r_addr + ADDR_WIDTH'(1);
        end else begin
          r_addr <= '0;
          if (!w_chan_end) r_chan <= r_chan + CW'(1);
        end
      end
    end
  end

  // Data lanes run from the top byte down to lane 0; the address lane sits above them.
  always_comb begin
    lane_en_o = '0;
    if (addr_mode_i) lane_en_o = BW'(1) << WORD_BYTES;
    else             lane_en_o = BW'(1) << (LW'(WORD_BYTES - 1) - r_lane);
  end

  always_comb begin
    chan_en_o = '0;
    for (int unsigned i = 0; i < CHAN_NUM; i++) begin
      if (bcast_i) chan_en_o[i] = (CW'(i) <= r_cnt);
      else         chan_en_o[i] = (CW'(i) == r_chan);
    end
  end

endmodule

// File: rtl/chan_wr_ctl.sv
// Command/data router from the SPI byte receiver to the register file and channel RAMs.
// Define CHAN_WR_CTL_BCAST_EN to enable the 0x2E broadcast write command.
module chan_wr_ctl
  import chan_wr_ctl_pkg::*;
#(
  parameter int unsigned CHAN_NUM   = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WORD_BYTES = 3,
  parameter int unsigned REG_NUM    = 8,
  localparam int unsigned CW = clog2_min1(CHAN_NUM),
  localparam int unsigned RW = clog2_min1(REG_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  dc_i,
  input  logic                  spi_byte_vld_i,
  input  logic [7:0]            spi_byte_data_i,
  input  logic [ADDR_WIDTH-1:0] reg_chan_len_i,
  input  logic [CW-1:0]         reg_chan_cnt_i,
  output logic                  reg_wr_en_o,
  output logic [RW-1:0]         reg_wr_addr_o,
  output logic [CHAN_NUM-1:0]   ram_wr_en_o,
  output logic                  ram_wr_done_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [WORD_BYTES:0]   ram_wr_byte_en_o,
  output logic                  ovf_o
);

  state_t              r_state;
  logic [RW-1:0]       r_reg_addr;
  logic [CW-1:0]       r_start;
  logic                r_ovf;

  cmd_t                  w_cmd;
  state_t                w_cmd_state;
  logic                  w_load;
  logic                  w_is_cmd;
  logic                  w_is_data;
  logic                  w_step;
  logic                  w_bcast;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [WORD_BYTES:0]   w_lane_en;
  logic [CHAN_NUM-1:0]   w_chan_en;

  assign w_cmd     = cmd_t'(spi_byte_data_i);
  assign w_is_cmd  = spi_byte_vld_i & ~dc_i;
  assign w_is_data = spi_byte_vld_i & dc_i;
  assign w_step    = w_is_data & ((r_state == ST_ADDR) | (r_state == ST_DATA) | (r_state == ST_BCAST));

`ifdef CHAN_WR_CTL_BCAST_EN
  assign w_bcast = (r_state == ST_BCAST);
`else
  assign w_bcast = 1'b0;
`endif

  // Command decode: target state and whether frame geometry is latched.
  always_comb begin
    w_cmd_state = ST_IDLE;
    w_load      = 1'b0;
    case (w_cmd)
      CMD_CONF_WR:  w_cmd_state = ST_CONF;
      CMD_CHAN_SEL: w_cmd_state = ST_CHSEL;
      CMD_ADDR_WR: begin
        w_cmd_state = ST_ADDR;
        w_load      = 1'b1;
      end
      CMD_DATA_WR: begin
        w_cmd_state = ST_DATA;
        w_load      = 1'b1;
      end
`ifdef CHAN_WR_CTL_BCAST_EN
      CMD_BCAST_WR: begin
        w_cmd_state = ST_BCAST;
        w_load      = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_reg_addr <= '0;
      r_start    <= '0;
      r_ovf      <= 1'b0;
    end else if (w_is_cmd) begin
      r_state    <= w_cmd_state;
      r_reg_addr <= '0;
      r_ovf      <= 1'b0;
    end else if (w_is_data) begin
      case (r_state)
        ST_CONF: begin
          if (r_reg_addr == RW'(REG_NUM - 1)) r_state <= ST_DROP;
          else                                r_reg_addr <= r_reg_addr + RW'(1);
        end
        // Start channel is checked against the count live at this byte, not a latched copy.
        ST_CHSEL: begin
          if (spi_byte_data_i[CW-1:0] <= reg_chan_cnt_i) r_start <= spi_byte_data_i[CW-1:0];
          else                                           r_ovf   <= 1'b1;
          r_state <= ST_DROP;
        end
        ST_ADDR, ST_DATA, ST_BCAST: begin
          if (w_last) r_state <= ST_DROP;
        end
        ST_DROP: r_ovf <= 1'b1;
        default: ;
      endcase
    end
  end

  chan_addr_seq #(
    .CHAN_NUM   (CHAN_NUM),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_BYTES (WORD_BYTES)
  ) u_seq (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clr_i        (w_is_cmd),
    .load_i       (w_load),
    .step_i       (w_step),
    .addr_mode_i  (r_state == ST_ADDR),
    .bcast_i      (w_bcast),
    .start_chan_i (r_start),
    .len_i        (reg_chan_len_i),
    .cnt_i        (reg_chan_cnt_i),
    .addr_o       (w_addr),
    .lane_en_o    (w_lane_en),
    .chan_en_o    (w_chan_en),
    .last_o       (w_last)
  );

  // Strobes are combinational with the byte valid; addresses come straight from counters.
  assign reg_wr_en_o      = w_is_data & (r_state == ST_CONF);
  assign reg_wr_addr_o    = r_reg_addr;
  assign ram_wr_en_o      = w_step ? w_chan_en : '0;
  assign ram_wr_done_o    = w_step & w_last;
  assign ram_wr_addr_o    = w_addr;
  assign ram_wr_byte_en_o = w_step ? w_lane_en : '0;
  assign ovf_o            = r_ovf;

endmodule

// File: tb/tb_chan_wr_ctl.sv
// Directed bench for chan_wr_ctl: byte-stream vector table plus reset/abort sequences.
module tb_chan_wr_ctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dc = 1'b0;
  logic        vld = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [7:0]  len = 8'h00;
  logic [3:0]  cnt = 4'h0;

  logic        reg_en;
  logic [2:0]  reg_addr;
  logic [15:0] ram_en;
  logic        done;
  logic [7:0]  addr;
  logic [3:0]  be;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  chan_wr_ctl dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .dc_i             (dc),
    .spi_byte_vld_i   (vld),
    .spi_byte_data_i  (data),
    .reg_chan_len_i   (len),
    .reg_chan_cnt_i   (cnt),
    .reg_wr_en_o      (reg_en),
    .reg_wr_addr_o    (reg_addr),
    .ram_wr_en_o      (ram_en),
    .ram_wr_done_o    (done),
    .ram_wr_addr_o    (addr),
    .ram_wr_byte_en_o (be),
    .ovf_o            (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dc;
    logic [7:0]  data;
    logic [7:0]  len;
    logic [3:0]  cnt;
    logic        reg_en;
    logic [2:0]  reg_addr;
    logic [15:0] ram_en;
    logic        done;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic        ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic d, input logic [7:0] b, input logic [7:0] l,
                              input logic [3:0] c, input logic re, input logic [2:0] ra,
                              input logic [15:0] we, input logic dn, input logic [7:0] a,
                              input logic [3:0] e, input logic o);
    vec_t v;
    v.dc = d; v.data = b; v.len = l; v.cnt = c;
    v.reg_en = re; v.reg_addr = ra; v.ram_en = we; v.done = dn;
    v.addr = a; v.be = e; v.ovf = o;
    return v;
  endfunction

  // DATA frame byte k with len=1 (two words of three bytes per channel).
  function automatic vec_t data_row(input int k, input int first_ch, input int last_k);
    return mk(1'b1, 8'(k), 8'd5, 4'd7, 1'b0, 3'd0, 16'(16'd1 << (first_ch + k / 6)),
              k == last_k, 8'((k / 3) % 2), 4'(4'd4 >> (k % 3)), 1'b0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " reg_en"},   32'(reg_en),   32'(v.reg_en));
    chk({tag, " reg_addr"}, 32'(reg_addr), 32'(v.reg_addr));
    chk({tag, " ram_en"},   32'(ram_en),   32'(v.ram_en));
    chk({tag, " done"},     32'(done),     32'(v.done));
    chk({tag, " addr"},     32'(addr),     32'(v.addr));
    chk({tag, " byte_en"},  32'(be),       32'(v.be));
    chk({tag, " ovf"},      32'(ovf),      32'(v.ovf));
  endtask

  task automatic drive(input logic d, input logic [7:0] b, input logic [7:0] l, input logic [3:0] c);
    @(negedge clk);
    dc = d; data = b; len = l; cnt = c; vld = 1'b1;
    #2;
  endtask

  task automatic idle();
    @(negedge clk);
    vld = 1'b0; dc = 1'b0;
    #2;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    vld = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
  endtask

  initial begin
    // CONF_WR: eight register writes, then overflow into DROP
    tbl.push_back(mk(0, 8'h2A, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1, 8'(8'h10 + k), 0, 0, 1, 3'(k), 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h99, 0, 0, 0, 3'd7, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h9A, 0, 0, 0, 3'd7, 0, 0, 0, 0, 1));
    // Unknown command returns to IDLE and clears ovf; IDLE data is ignored
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 3'd7, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // DATA_WR len=1 cnt=1; live len/cnt change during the frame must be ignored
    tbl.push_back(mk(0, 8'h2C, 8'd1, 4'd1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 12; k++) tbl.push_back(data_row(k, 0, 11));
    tbl.push_back(mk(1, 8'hEE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hEF, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // CHAN_SEL 1 then DATA_WR: only channel 1
    tbl.push_back(mk(0, 8'h2D, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h01, 0, 4'd1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h2C, 8'd1, 4'd1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++) tbl.push_back(data_row(k, 1, 5));
    tbl.push_back(mk(1, 8'hEE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hEF, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // CHAN_SEL 0 valid, CHAN_SEL 5 > cnt ignored, then ADDR_WR len=0 cnt=2
    tbl.push_back(mk(0, 8'h2D, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h00, 0, 4'd1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h2D, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h05, 0, 4'd1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 4'd1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h2B, 8'd0, 4'd2, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 8'(k), 8'd5, 4'd7, 0, 0, 16'(16'd1 << k), k == 2, 0, 4'h8, 0));
    tbl.push_back(mk(1, 8'hEE, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'hEF, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // BCAST_WR len=0 cnt=3
    tbl.push_back(mk(0, 8'h2E, 8'd0, 4'd3, 0, 0, 0, 0, 0, 0, 1));
`ifdef CHAN_WR_CTL_BCAST_EN
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 8'(k), 8'd5, 4'd7, 0, 0, 16'h000F, k == 2, 0, 4'(4'd4 >> k), 0));
`else
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 8'(k), 8'd5, 4'd7, 0, 0, 16'h0000, 0, 0, 4'h0, 0));
`endif
    tbl.push_back(mk(1, 8'hEE, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset values
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check_vec("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].dc, tbl[i].data, tbl[i].len, tbl[i].cnt);
      check_vec($sformatf("v%0d", i), tbl[i]);
    end
    idle();

    // Command mid-DATA clears address and lane counters
    drive(0, 8'h2C, 8'd1, 4'd1);
    for (int k = 0; k < 4; k++) begin
      drive(1, 8'(k), 8'd5, 4'd7);
      check_vec($sformatf("midA%0d", k), data_row(k, 0, 11));
    end
    drive(0, 8'h2C, 8'd1, 4'd1);
    check_vec("midcmd", mk(0, 0, 0, 0, 0, 0, 0, 0, 8'd1, 0, 0));
    for (int k = 0; k < 11; k++) begin
      drive(1, 8'(k), 8'd5, 4'd7);
      check_vec($sformatf("midB%0d", k), data_row(k, 0, 11));
    end
    // Reset one byte before the end of the frame: no done, back to IDLE
    pulse_reset();
    check_vec("rst_mid", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(1, 8'h77, 8'd5, 4'd7);
    check_vec("post_rst", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle();

    // Reset clears sticky ovf and the start channel
    drive(0, 8'h2D, 0, 4'd1);
    drive(1, 8'h01, 0, 4'd1);
    drive(1, 8'h00, 0, 4'd1);
    idle();
    chk("ovf_set", 32'(ovf), 32'd1);
    pulse_reset();
    chk("ovf_rst", 32'(ovf), 32'd0);
    drive(0, 8'h2C, 8'd0, 4'd1);
    drive(1, 8'h00, 8'd0, 4'd1);
    check_vec("start_rst", mk(1, 0, 0, 0, 0, 0, 16'h0001, 0, 0, 4'h4, 0));
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
